// File: rtl/twiddle_seq.sv
// Twiddle ROM read sequencer: walks every stage/butterfly, issues ROM reads under
// FIFO credit, buffers returns in a fall-through FIFO. Optional macro: TWIDDLE_CONJ_EN.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | waiting for start
// S_RUN   | issuing addresses while credit is available
// S_DRAIN | all addresses issued, emptying pipe and FIFO
// S_DONE  | one-cycle done pulse
module twiddle_seq #(
  parameter int FFT_SIZE      = 4096,
  parameter int TWIDDLE_WIDTH = 50,
  parameter int ROM_LATENCY   = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              inverse,
  output logic [$clog2(FFT_SIZE/2)-1:0]     twiddle_addr,
  input  logic [TWIDDLE_WIDTH-1:0]          twiddle_in,
  output logic [TWIDDLE_WIDTH-1:0]          tw_data,
  output logic [$clog2($clog2(FFT_SIZE))-1:0] tw_stage,
  output logic [$clog2(FFT_SIZE)-2:0]       tw_bfly,
  output logic                              tw_valid,
  input  logic                              tw_ready,
  output logic                              busy,
  output logic                              done
);
  localparam int LOG2N = $clog2(FFT_SIZE);
  localparam int AW    = LOG2N - 1;
  localparam int SW    = $clog2(LOG2N);
  localparam int TGW   = SW + AW;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int HALF  = TWIDDLE_WIDTH / 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]               r_state;
  logic [SW-1:0]            r_s;
  logic [AW-1:0]            r_b;
  logic [ROM_LATENCY-1:0]   r_pipe_v;
  logic [TGW-1:0]           r_pipe_tag [ROM_LATENCY];
  logic [CW-1:0]            r_infl;
  logic [CW-1:0]            r_cnt;
  logic [PW-1:0]            r_wr_ptr;
  logic [PW-1:0]            r_rd_ptr;
  logic [TWIDDLE_WIDTH-1:0] r_mem_d [FIFO_DEPTH];
  logic [TGW-1:0]           r_mem_t [FIFO_DEPTH];

  logic                     w_issue;
  logic                     w_last;
  logic                     w_push;
  logic                     w_pop;
  logic [CW-1:0]            w_cnt_nxt;
  logic [CW-1:0]            w_infl_nxt;
  logic [AW-1:0]            w_mask;
  logic [TWIDDLE_WIDTH-1:0] w_push_data;

  // Credit counts words already buffered plus reads still in the ROM pipe.
  assign w_issue    = (r_state == S_RUN) &&
                      (({1'b0, r_cnt} + {1'b0, r_infl}) < (CW+1)'(FIFO_DEPTH));
  assign w_last     = (r_s == SW'(LOG2N - 1)) && (r_b == '1);
  assign w_push     = r_pipe_v[ROM_LATENCY-1];
  assign w_pop      = (r_cnt != '0) && tw_ready;
  assign w_cnt_nxt  = r_cnt + CW'(w_push) - CW'(w_pop);
  assign w_infl_nxt = r_infl + CW'(w_issue) - CW'(w_push);

  assign w_mask       = (AW'(1) << r_s) - AW'(1);
  assign twiddle_addr = (r_b & w_mask) << (SW'(LOG2N - 1) - r_s);

`ifdef TWIDDLE_CONJ_EN
  logic            r_inverse;
  logic [HALF-1:0] w_im;
  assign w_im = twiddle_in[HALF-1:0];

  // Conjugate on write; the most negative imaginary value saturates.
  always_comb begin
    w_push_data = twiddle_in;
    if (r_inverse) begin
      w_push_data[HALF-1:0] = (w_im == {1'b1, {(HALF-1){1'b0}}}) ?
                              {1'b0, {(HALF-1){1'b1}}} : -w_im;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_inverse <= 1'b0;
    else if (r_state == S_IDLE && start) r_inverse <= inverse;
  end
`else
  logic w_unused_inverse;
  assign w_unused_inverse = inverse;
  assign w_push_data      = twiddle_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_s     <= '0;
      r_b     <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (start) r_state <= S_RUN;
        S_RUN:   if (w_issue && w_last) r_state <= S_DRAIN;
        S_DRAIN: if (w_infl_nxt == '0 && w_cnt_nxt == '0) r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
      if (w_issue) begin
        if (w_last) begin
          r_s <= '0;
          r_b <= '0;
        end else if (r_b == '1) begin
          r_b <= '0;
          r_s <= r_s + SW'(1);
        end else begin
          r_b <= r_b + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_v <= '0;
      r_infl   <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) r_pipe_tag[i] <= '0;
    end else begin
      r_pipe_v[0]   <= w_issue;
      r_pipe_tag[0] <= {r_s, r_b};
      for (int i = 1; i < ROM_LATENCY; i++) begin
        r_pipe_v[i]   <= r_pipe_v[i-1];
        r_pipe_tag[i] <= r_pipe_tag[i-1];
      end
      r_infl <= w_infl_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_d[i] <= '0;
        r_mem_t[i] <= '0;
      end
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_push) begin
        r_mem_d[r_wr_ptr] <= w_push_data;
        r_mem_t[r_wr_ptr] <= r_pipe_tag[ROM_LATENCY-1];
        r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
      end
    end
  end

  assign tw_valid            = (r_cnt != '0);
  assign tw_data             = r_mem_d[r_rd_ptr];
  assign {tw_stage, tw_bfly} = r_mem_t[r_rd_ptr];
  assign busy                = (r_state != S_IDLE);
  assign done                = (r_state == S_DONE);

endmodule

// File: tb/tb_twiddle_seq.sv
// Directed bench for twiddle_seq: full sequences with steady and random back-pressure,
// mid-run reset, ignored starts, stall/hold, and the TWIDDLE_CONJ_EN conjugate path.
module tb_twiddle_seq;
  localparam int NWORDS = 24576;

`ifdef TWIDDLE_CONJ_EN
  localparam logic [24:0] IM1000_INV = 25'h1FFFC18;
  localparam logic [24:0] IMMIN_INV  = 25'h0FFFFFF;
`else
  localparam logic [24:0] IM1000_INV = 25'd1000;
  localparam logic [24:0] IMMIN_INV  = 25'h1000000;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, inverse, tw_ready;
  logic [10:0] twiddle_addr;
  logic [49:0] twiddle_in, tw_data, rom_q;
  logic [3:0]  tw_stage;
  logic [10:0] tw_bfly;
  logic        tw_valid, busy, done;

  int total = 0, bad = 0, cyc = 0;
  int e_s, e_b, n_acc, n_done, done_cyc, last_acc_cyc;
  logic e_inv, stalled;

  twiddle_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inverse(inverse),
    .twiddle_addr(twiddle_addr), .twiddle_in(twiddle_in),
    .tw_data(tw_data), .tw_stage(tw_stage), .tw_bfly(tw_bfly),
    .tw_valid(tw_valid), .tw_ready(tw_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [49:0] rom_f(input logic [10:0] a);
    int ai;
    logic [24:0] re, im;
    ai = int'(a);
    re = 25'(ai * 1000 + 12345);
    im = (ai == 0) ? 25'h1000000 : 25'(ai * 1000);
    return {re, im};
  endfunction

  function automatic int addr_of(input int s, input int b);
    return ((b & ((1 << s) - 1)) << (11 - s)) & 2047;
  endfunction

  function automatic logic [49:0] exp_data(input int a, input logic inv);
    logic [49:0] d;
    d = rom_f(11'(a));
`ifdef TWIDDLE_CONJ_EN
    if (inv) d[24:0] = (d[24:0] == 25'h1000000) ? 25'h0FFFFFF : 25'(-d[24:0]);
`else
    if (inv) d = d;
`endif
    return d;
  endfunction

  always @(posedge clk) rom_q <= rom_f(twiddle_addr);
  assign twiddle_in = rom_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, drive tw_ready, and score any handshake in this cycle.
  task automatic tick(input logic rdy);
    @(posedge clk);
    #1;
    cyc++;
    tw_ready = rdy;
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (tw_valid && tw_ready) begin
      chk("tag", {tw_stage, tw_bfly}, {4'(e_s), 11'(e_b)});
      chk("data", tw_data, exp_data(addr_of(e_s, e_b), e_inv));
      if (e_s == 11 && e_b == 5) chk("s11b5_addr5", tw_data, {25'd17345, 25'd5000});
      if (e_s == 1 && e_b == 3) chk("s1b3_addr1024", tw_data, {25'd1036345, 25'd1024000});
      if (e_s == 11 && e_b == 1) chk("imag_1000", tw_data[24:0], e_inv ? IM1000_INV : 25'd1000);
      if (e_s == 0 && e_b == 0) chk("imag_min", tw_data[24:0], e_inv ? IMMIN_INV : 25'h1000000);
      last_acc_cyc = cyc;
      n_acc++;
      if (e_b == 2047) begin
        e_b = 0;
        e_s++;
      end else begin
        e_b++;
      end
    end
  endtask

  task automatic seq_reset(input logic inv);
    e_s = 0; e_b = 0; e_inv = inv; n_acc = 0; n_done = 0;
    done_cyc = -1; last_acc_cyc = -1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; inverse = 1'b0; tw_ready = 1'b0; stalled = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", twiddle_addr, 0);
    chk("rst_data", tw_data, 0);
    chk("rst_stage", tw_stage, 0);
    chk("rst_bfly", tw_bfly, 0);
    chk("rst_valid", tw_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    tick(1'b0);

    // Run A: ready held high, stray start at cycle 50, one mid-stream stall.
    seq_reset(1'b0);
    cyc = 0; start = 1'b1; inverse = 1'b0;
    tick(1'b1);
    start = 1'b0;
    chk("c1_busy", busy, 1);
    chk("c1_addr", twiddle_addr, 0);
    chk("c1_valid", tw_valid, 0);
    tick(1'b1);
    chk("c2_valid", tw_valid, 0);
    tick(1'b1);
    chk("c3_valid", tw_valid, 1);
    while (n_acc < NWORDS && cyc < 30000) begin
      tick(1'b1);
      start = (cyc == 50);
      inverse = (cyc >= 50);
      if (!stalled && e_s == 11 && e_b == 11) begin
        stalled = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
          tick(1'b0);
          if (i == 2 || i == 19) begin
            chk("hold_addr", twiddle_addr, 15);
            chk("hold_tag", {tw_stage, tw_bfly}, {4'd11, 11'd11});
          end
          if (i == 19) chk("hold_data", tw_data, exp_data(11, 1'b0));
        end
      end
    end
    start = 1'b0;
    chk("a_count", n_acc, NWORDS);
    tick(1'b1);
    chk("a_done_k1", done, 1);
    chk("a_busy_k1", busy, 1);
    start = 1'b1;
    tick(1'b1);
    start = 1'b0;
    chk("a_done_k2", done, 0);
    chk("a_busy_k2", busy, 0);
    repeat (4) tick(1'b1);
    chk("a_busy_after", busy, 0);
    chk("a_done_cnt", n_done, 1);
    chk("a_done_cyc", done_cyc, last_acc_cyc + 1);
    chk("a_no_extra", n_acc, NWORDS);

    // Run B: reset asserted mid-run after (0,100) is consumed.
    seq_reset(1'b0);
    cyc = 0; start = 1'b1; inverse = 1'b1;
    tick(1'b1);
    start = 1'b0;
    while (!(e_s == 0 && e_b == 101) && cyc < 400) tick(1'b1);
    rst_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_valid", tw_valid, 0);
    chk("mr_out", {tw_data, tw_stage, tw_bfly}, 0);
    chk("mr_addr", twiddle_addr, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mr_done", done, 0);
    tick(1'b0);
    chk("mr_idle", busy, 0);

    // Run C: inverse latched, 20-cycle stall at start, then random ready.
    seq_reset(1'b1);
    cyc = 0; start = 1'b1; inverse = 1'b1;
    tick(1'b0);
    start = 1'b0;
    inverse = 1'b0;
    repeat (19) tick(1'b0);
    chk("st_valid", tw_valid, 1);
    chk("st_tag", {tw_stage, tw_bfly}, 0);
    chk("st_data", tw_data, {25'd12345, IMMIN_INV});
    while (n_acc < NWORDS && cyc < 60000) tick(1'(($urandom_range(0, 1))));
    for (int i = 0; i < 6 && n_done == 0; i++) tick(1'b1);
    chk("c_count", n_acc, NWORDS);
    chk("c_done_cnt", n_done, 1);
    tick(1'b1);
    chk("c_busy_end", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/twiddle_seq.md
# twiddle_seq

Twiddle read sequencer for the radix-2 FFT datapath: the initiator side of the twiddle ROM read port. On a start pulse it walks every stage and butterfly of an FFT_SIZE-point transform. For each butterfly it computes the ROM address, issues it, tracks reads in flight across the fixed ROM latency, and buffers returned words in a small FIFO. Twiddles go to the butterfly unit over a valid/ready stream, tagged with stage and butterfly index.

## Interface
- FFT_SIZE, 4096, transform points (power of two); LOG2N = $clog2(FFT_SIZE)
- TWIDDLE_WIDTH, 50, ROM word: [49:25] real, [24:0] imaginary, two's complement
- ROM_LATENCY, 1, clk cycles from address presented to ROM data valid (registered douta)
- FIFO_DEPTH, 4, return buffer entries; must be >= ROM_LATENCY+2 for full throughput
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to sequence one transform; ignored unless idle
- inverse  in  1  sampled with accepted start; selects inverse transform
- twiddle_addr  out  $clog2(FFT_SIZE/2)  ROM address
- twiddle_in  in  TWIDDLE_WIDTH  ROM data, valid ROM_LATENCY cycles after address issue
- tw_data  out  TWIDDLE_WIDTH  twiddle to butterfly unit
- tw_stage  out  $clog2(LOG2N)  stage tag of tw_data
- tw_bfly  out  LOG2N-1  butterfly tag of tw_data
- tw_valid  out  1  tw_data/tags valid
- tw_ready  in  1  consumer accepts when tw_valid & tw_ready
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last twiddle accepted

## Operation
- FSM: IDLE -> RUN on start; RUN -> DRAIN after last address issued; DRAIN -> DONE when nothing in flight and FIFO empty; DONE -> IDLE unconditionally (done=1 in DONE).
- Counters: stage s 0..LOG2N-1 (outer), butterfly b 0..FFT_SIZE/2-1 (inner); b wraps to 0 and s increments; last issue is s=LOG2N-1, b=FFT_SIZE/2-1.
- Address: twiddle_addr = (b & ((1<<s)-1)) << (LOG2N-1-s); stage 0 always 0; last stage equals b.
- Issue rule: in RUN, issue (counters advance) when fifo_count + inflight < FIFO_DEPTH; same-cycle pops are not credited. No issue -> counters hold, twiddle_addr holds.
- In-flight tracking: ROM_LATENCY-deep shift register carrying issue flag plus {s,b} tag; at exit, twiddle_in and tag are written to FIFO.
- FIFO: first-word fall-through; head drives tw_data/tw_stage/tw_bfly, tw_valid = !empty. Simultaneous push and pop at any count is legal and count is unchanged. Overflow cannot occur under the issue rule.
- Output holds stable while tw_valid & !tw_ready.
- start while busy: ignored, no effect on counters or inverse latch.
- Reset at any time: FSM IDLE, counters, in-flight, FIFO cleared; in-flight ROM data discarded.
- Reset values: twiddle_addr=0, tw_data=0, tw_stage=0, tw_bfly=0, tw_valid=0, busy=0, done=0.

## Timing
- start sampled high at edge ending cycle 0 -> busy=1 and first address in cycle 1.
- Address issued in cycle t -> word in FIFO at edge ending t+ROM_LATENCY -> tw_valid in t+ROM_LATENCY+1 (cycle 3 for first word at defaults).
- Sustained throughput 1 twiddle/cycle with tw_ready held high; 24576 twiddles at defaults.
- Final handshake in cycle k -> done=1 in k+1, busy falls in k+2; new start accepted from k+2.
- Back-pressure: issue halts within one cycle of credit exhaustion; no word lost or duplicated.

## Configuration
- TWIDDLE_CONJ_EN defined: when the latched inverse is 1, the imaginary field is negated on FIFO write (real unchanged). -2^24 saturates to 2^24-1. No added latency.
- Undefined: inverse is ignored; tw_data equals the ROM word exactly.

## Test plan
- Reset mid-RUN (rst_n low 3 cycles at b=100) -> all outputs 0, FSM IDLE; next start sequences from s=0,b=0.
- start, tw_ready=1, model ROM latency 1 -> first tw_valid at cycle 3 with s=0,b=0, addr 0; stage 11 b=5 uses addr 5; stage 1 b=3 uses addr 1024; 24576 words, done once.
- Random tw_ready (50%) -> identical ordered stream, tags contiguous, FIFO never exceeds 4, no drops or duplicates.
- tw_ready=0 for 20 cycles at start -> exactly 4 words issued, then addr holds; release -> stream resumes in order.
- start re-pulsed at cycle 50 and the same cycle as done -> ignored; busy stays low after done until a fresh start.
- TWIDDLE_CONJ_EN, inverse=1, ROM word imag=-2^24 and imag=1000 -> outputs imag 2^24-1 and -1000; inverse=0 passes the word unchanged.
